// File: rtl/fifo_stream2native.sv
// Stream-to-native FIFO write adapter with a 2-entry skid buffer.
// Ports: clk, rst_n, s_axis_* (in), full (in), wr_en/din/word_count (out).
module fifo_stream2native #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  full,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] din,
  output logic [31:0]           word_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_n;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] head_n;
  logic [DATA_WIDTH-1:0] tail;
  logic [DATA_WIDTH-1:0] tail_n;
  logic [31:0]           cnt_q;
  logic                  accept;

  assign accept     = s_axis_tvalid & s_axis_tready;
  assign wr_en      = (state != EMPTY) & ~full;
  assign din        = head;
  assign word_count = cnt_q;

  always_comb begin
    state_n = state;
    head_n  = head;
    tail_n  = tail;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          head_n  = s_axis_tdata;
          state_n = ONE;
        end
      end
      ONE: begin
        if (wr_en && accept) begin
          head_n = s_axis_tdata;
        end else if (wr_en) begin
          state_n = EMPTY;
        end else if (accept) begin
          tail_n  = s_axis_tdata;
          state_n = TWO;
        end
      end
      TWO: begin
        // tready is low here, so only a drain can happen
        if (wr_en) begin
          head_n  = tail;
          state_n = ONE;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= EMPTY;
      s_axis_tready <= 1'b0;
      cnt_q         <= '0;
      head          <= '0;
      tail          <= '0;
    end else begin
      state         <= state_n;
      s_axis_tready <= (state_n != TWO);
      cnt_q         <= cnt_q + {31'd0, wr_en};
      head          <= head_n;
      tail          <= tail_n;
    end
  end

endmodule

// File: tb/tb_fifo_stream2native.sv
// Directed self-checking bench for fifo_stream2native.
// Scoreboard checks every FIFO write against hand-listed words.
module tb_fifo_stream2native;

  localparam int DW = 64;

  logic          clk;
  logic          rst_n;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          full;
  logic          wr_en;
  logic [DW-1:0] din;
  logic [31:0]   word_count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  fifo_stream2native #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .full          (full),
    .wr_en         (wr_en),
    .din           (din),
    .word_count    (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write must match the next expected word
  always @(posedge clk) begin
    if (wr_en) begin
      checks++;
      assert (full === 1'b0) else begin
        errors++;
        $error("FAIL wr_while_full: got wr_en=1 expected 0");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL stray_write: got din=%0h expected no write", din);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        assert (din === e) else begin
          errors++;
          $error("FAIL write_order: got %0h expected %0h", din, e);
        end
      end
    end
  end

  initial begin
    int idx;
    int n;
    logic acc;

    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    full          = 1'b0;

    // Reset
    cyc();
    cyc();
    chk("rst_tready", DW'(s_axis_tready), 0);
    chk("rst_wr_en", DW'(wr_en), 0);
    chk("rst_count", DW'(word_count), 0);
    chk("rst_din", din, 0);
    rst_n = 1'b1;
    cyc();
    chk("tready_rise", DW'(s_axis_tready), 1);

    // Three words, full low
    exp_q.push_back(64'h1);
    exp_q.push_back(64'h2);
    exp_q.push_back(64'h3);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 64'h1;
    chk("no_bypass", DW'(wr_en), 0);
    cyc();
    chk("w1_wr", DW'(wr_en), 1);
    chk("w1_din", din, 64'h1);
    s_axis_tdata = 64'h2;
    cyc();
    chk("w2_din", din, 64'h2);
    s_axis_tdata = 64'h3;
    cyc();
    chk("w3_din", din, 64'h3);
    chk("w3_wr", DW'(wr_en), 1);
    s_axis_tvalid = 1'b0;
    cyc();
    chk("w_idle", DW'(wr_en), 0);
    chk("w_count", DW'(word_count), 3);

    // Backpressure fills both entries
    exp_q.push_back(64'hA);
    exp_q.push_back(64'hB);
    exp_q.push_back(64'hC);
    full          = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 64'hA;
    cyc();
    chk("bp_tready1", DW'(s_axis_tready), 1);
    chk("bp_wr1", DW'(wr_en), 0);
    s_axis_tdata = 64'hB;
    cyc();
    chk("bp_tready2", DW'(s_axis_tready), 0);
    chk("bp_wr2", DW'(wr_en), 0);
    s_axis_tdata = 64'hC;
    cyc();
    chk("bp_hold_tready", DW'(s_axis_tready), 0);
    chk("bp_hold_din", din, 64'hA);
    full = 1'b0;
    #1;
    chk("bp_drain_wr", DW'(wr_en), 1);
    chk("bp_drain_a", din, 64'hA);
    cyc();
    chk("bp_drain_b", din, 64'hB);
    chk("bp_tready3", DW'(s_axis_tready), 1);
    cyc();
    chk("bp_drain_c", din, 64'hC);
    s_axis_tvalid = 1'b0;
    cyc();
    chk("bp_idle", DW'(wr_en), 0);
    chk("bp_count", DW'(word_count), 6);

    // Full toggling every cycle, 16 words
    for (int i = 0; i < 16; i++) exp_q.push_back(64'h100 + 64'(i));
    idx = 0;
    n   = 0;
    while (idx < 16 && n < 100) begin
      full          = n[0];
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 64'h100 + 64'(idx);
      acc = s_axis_tready;
      cyc();
      if (acc) idx++;
      n++;
    end
    chk("tog_all_accepted", DW'(idx), 16);
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    for (int i = 0; i < 6; i++) begin
      full = i[0];
      cyc();
    end
    full = 1'b0;
    cyc();
    chk("tog_count", DW'(word_count), 22);
    chk("tog_drained", DW'(exp_q.size()), 0);

    // Reset while two words are buffered
    full          = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 64'h5;
    cyc();
    s_axis_tdata = 64'h6;
    cyc();
    chk("rs_two", DW'(s_axis_tready), 0);
    rst_n        = 1'b0;
    s_axis_tdata = 64'h7;
    cyc();
    chk("rs_wr", DW'(wr_en), 0);
    chk("rs_count", DW'(word_count), 0);
    chk("rs_tready", DW'(s_axis_tready), 0);
    rst_n         = 1'b1;
    full          = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    chk("rs_rel_wr", DW'(wr_en), 0);
    cyc();
    chk("rs_rel_tready", DW'(s_axis_tready), 1);
    chk("rs_rel_wr2", DW'(wr_en), 0);
    cyc();
    chk("rs_rel_count", DW'(word_count), 0);

    // Counter wrap
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    exp_q.push_back(64'h21);
    exp_q.push_back(64'h22);
    exp_q.push_back(64'h23);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 64'h21;
    cyc();
    chk("wrap_pre", DW'(word_count), 64'hFFFF_FFFE);
    s_axis_tdata = 64'h22;
    cyc();
    chk("wrap_max", DW'(word_count), 64'hFFFF_FFFF);
    s_axis_tdata = 64'h23;
    cyc();
    chk("wrap_zero", DW'(word_count), 0);
    s_axis_tvalid = 1'b0;
    cyc();
    chk("wrap_one", DW'(word_count), 1);

    // tdata noise without tvalid
    for (int i = 0; i < 10; i++) begin
      s_axis_tdata = {$urandom, $urandom};
      #1;
      chk("noise_wr", DW'(wr_en), 0);
      cyc();
    end
    chk("noise_tready", DW'(s_axis_tready), 1);
    chk("noise_count", DW'(word_count), 1);
    chk("final_drained", DW'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
